// File: rtl/counter_ctrl_unit.sv
// Button front end and run/stop/clear controller for the counter datapath.
// Raw buttons are synchronized, debounced and edge-detected; a Moore FSM turns presses into registered controls.
module counter_ctrl_unit #(
    parameter int DB_CYCLES = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_clear,
    input  logic btn_dir,
    input  logic btn_mode,
    output logic en,
    output logic clear,
    output logic up_down,
    output logic mode
);

    localparam int NUM_BTN = 4;
    localparam int BTN_RUN = 0;
    localparam int BTN_CLR = 1;
    localparam int BTN_DIR = 2;
    localparam int BTN_MOD = 3;

    localparam int CNT_W = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DB_CYCLES < 1) ? 0 : DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Saturating increment: the stability counter must never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [NUM_BTN-1:0] btn_raw_s;
    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    logic [NUM_BTN-1:0] deb_r;
    logic [NUM_BTN-1:0] deb_dly_r;
    logic [NUM_BTN-1:0] press_s;
    logic [CNT_W-1:0]   cnt_r [NUM_BTN];

    state_t state_r;
    state_t state_next_s;
    logic   en_r;
    logic   clear_r;
    logic   up_down_r;
    logic   mode_r;

    assign btn_raw_s = {btn_mode, btn_dir, btn_clear, btn_run};

    // Two-flop synchronizer for all raw button inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {NUM_BTN{1'b0}};
            sync2_r <= {NUM_BTN{1'b0}};
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] >= CNT_LAST) begin
                    deb_r[i] <= sync2_r[i];
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= sat_inc(cnt_r[i]);
                end
            end
        end
    end

    // Delayed debounced level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_dly_r <= {NUM_BTN{1'b0}};
        end else begin
            deb_dly_r <= deb_r;
        end
    end

    // Press events: one cycle per rising edge of the debounced level, none on release.
    always_comb begin
        press_s = deb_r & ~deb_dly_r;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_STOP;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; clear wins over run in STOP, and nothing is queued across states.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_STOP: begin
                if (press_s[BTN_CLR]) begin
                    state_next_s = ST_CLEAR;
                end else if (press_s[BTN_RUN]) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (press_s[BTN_RUN]) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_CLEAR: begin
                state_next_s = ST_STOP;
            end
            default: begin
                state_next_s = ST_STOP;
            end
        endcase
    end

    // Registered Moore outputs, decoded from the next state so they track state_r exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r      <= 1'b0;
            clear_r   <= 1'b0;
            up_down_r <= 1'b1;
            mode_r    <= 1'b0;
        end else begin
            en_r      <= (state_next_s == ST_RUN);
            clear_r   <= (state_next_s == ST_CLEAR);
            up_down_r <= up_down_r ^ press_s[BTN_DIR];
            mode_r    <= mode_r ^ press_s[BTN_MOD];
        end
    end

    assign en      = en_r;
    assign clear   = clear_r;
    assign up_down = up_down_r;
    assign mode    = mode_r;

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Directed self-checking bench for counter_ctrl_unit with DB_CYCLES = 4.
// Expected values are hand-derived from the debounce latency and FSM rules.
module tb_counter_ctrl_unit;

    localparam int DB = 4;

    logic clk;
    logic reset;
    logic btn_run;
    logic btn_clear;
    logic btn_dir;
    logic btn_mode;
    logic en;
    logic clear;
    logic up_down;
    logic mode;

    int n_cmp;
    int n_err;

    // Activity statistics gathered by cyc()
    int en_rise;
    int en_hi;
    int clr_hi;
    int ud_tog;
    int md_tog;
    int first_en;
    int cyc_idx;
    logic en_prev;
    logic ud_prev;
    logic md_prev;

    counter_ctrl_unit #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .btn_dir   (btn_dir),
        .btn_mode  (btn_mode),
        .en        (en),
        .clear     (clear),
        .up_down   (up_down),
        .mode      (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        en_rise  = 0;
        en_hi    = 0;
        clr_hi   = 0;
        ud_tog   = 0;
        md_tog   = 0;
        first_en = 0;
        cyc_idx  = 0;
        en_prev  = en;
        ud_prev  = up_down;
        md_prev  = mode;
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc_idx++;
            if (en && !en_prev) en_rise++;
            if (en && first_en == 0) first_en = cyc_idx;
            if (en) en_hi++;
            if (clear) clr_hi++;
            if (up_down !== ud_prev) ud_tog++;
            if (mode !== md_prev) md_tog++;
            en_prev = en;
            ud_prev = up_down;
            md_prev = mode;
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_dir   = 1'b0;
        btn_mode  = 1'b0;
        clr_stats();
        cyc(3);

        // Reset state
        check("rst_en", en, 0);
        check("rst_clear", clear, 0);
        check("rst_up_down", up_down, 1);
        check("rst_mode", mode, 0);
        reset = 1'b0;
        cyc(3);

        // Run press: en rises once, DB+3 cycles after the raw edge
        clr_stats();
        btn_run = 1'b1;
        cyc(20);
        check("run_first_en_cycle", first_en, 7);
        check("run_latency_in_window", int'(first_en >= 7 && first_en <= 9), 1);
        check("run_en_rises_once", en_rise, 1);
        check("run_en_held", en, 1);
        btn_run = 1'b0;
        cyc(10);
        check("run_release_no_event", en, 1);
        btn_run = 1'b1;
        cyc(12);
        check("run_second_press_stops", en, 0);
        btn_run = 1'b0;
        cyc(10);

        // Clear from STOP: one-cycle pulse, en stays low
        clr_stats();
        btn_clear = 1'b1;
        cyc(20);
        check("stop_clear_pulse_len", clr_hi, 1);
        check("stop_clear_en_low", en_hi, 0);
        btn_clear = 1'b0;
        cyc(10);
        check("stop_clear_after", clear, 0);

        // Clear ignored in RUN, and not replayed after returning to STOP
        btn_run = 1'b1;
        cyc(12);
        btn_run = 1'b0;
        cyc(8);
        check("run_clear_pre_en", en, 1);
        clr_stats();
        btn_clear = 1'b1;
        cyc(12);
        btn_clear = 1'b0;
        cyc(8);
        check("run_clear_no_pulse", clr_hi, 0);
        check("run_clear_en_stays", en_hi, 20);
        btn_run = 1'b1;
        cyc(12);
        btn_run = 1'b0;
        check("run_stop_after_clear", en, 0);
        clr_stats();
        cyc(20);
        check("no_delayed_clear", clr_hi, 0);

        // Run and clear together in STOP: clear wins
        clr_stats();
        btn_run   = 1'b1;
        btn_clear = 1'b1;
        cyc(20);
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        cyc(10);
        check("both_clear_pulses", clr_hi, 1);
        check("both_en_never", en_hi, 0);
        check("both_final_en", en, 0);

        // Dir bounce of 2-cycle glitches, then a steady hold
        clr_stats();
        btn_dir = 1'b1; cyc(2);
        btn_dir = 1'b0; cyc(2);
        btn_dir = 1'b1; cyc(2);
        btn_dir = 1'b0; cyc(2);
        check("dir_glitch_no_toggle", ud_tog, 0);
        btn_dir = 1'b1; cyc(20);
        check("dir_toggles_once", ud_tog, 1);
        check("dir_up_down_low", up_down, 0);
        btn_dir = 1'b0;
        cyc(10);

        // Mode pressed twice: 0 -> 1 -> 0
        btn_mode = 1'b1; cyc(12);
        btn_mode = 1'b0; cyc(10);
        check("mode_first_press", mode, 1);
        btn_mode = 1'b1; cyc(12);
        btn_mode = 1'b0; cyc(10);
        check("mode_second_press", mode, 0);

        // Build RUN with up_down=0 and mode=1, then reset mid-cycle
        btn_mode = 1'b1; cyc(12);
        btn_mode = 1'b0; cyc(10);
        btn_run  = 1'b1; cyc(12);
        btn_run  = 1'b0; cyc(8);
        check("pre_rst_en", en, 1);
        check("pre_rst_up_down", up_down, 0);
        check("pre_rst_mode", mode, 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_en", en, 0);
        check("async_rst_up_down", up_down, 1);
        check("async_rst_mode", mode, 0);
        cyc(3);
        reset = 1'b0;
        clr_stats();
        cyc(20);
        check("post_rst_quiet", en_hi + clr_hi + ud_tog + md_tog, 0);

        // A button held through reset release counts as a fresh press
        btn_run = 1'b1;
        reset   = 1'b1;
        cyc(3);
        reset = 1'b0;
        clr_stats();
        cyc(20);
        check("held_thru_rst_event", en_rise, 1);
        check("held_thru_rst_latency", first_en, DB + 3);
        btn_run = 1'b0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_ctrl_unit.md
COUNTER_CTRL_UNIT -- requirements
Module: counter_ctrl_unit

Interface
REQ-001 Parameter: DB_CYCLES, default 100_000, number of consecutive stable clk cycles required to accept a button level (1 ms at 100 MHz).
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 btn_run  input  1  raw, asynchronous run/stop push button, active-high.
REQ-005 btn_clear  input  1  raw clear push button, active-high.
REQ-006 btn_dir  input  1  raw count-direction toggle button, active-high.
REQ-007 btn_mode  input  1  raw display-mode toggle button, active-high.
REQ-008 en  output  1  counter run enable, which drives the counter's en.
REQ-009 clear  output  1  single-cycle counter clear pulse.
REQ-010 up_down  output  1  count direction, 1 = up, 0 = down.
REQ-011 mode  output  1  display-mode select for the dot comparator.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per button, the debounced level SHALL take the synchronized value only after that value has differed from the current debounced level for DB_CYCLES consecutive cycles. Any reversion before that SHALL restart the stability count at zero.
REQ-014 Debounce counters SHALL be sized to ceil(log2(DB_CYCLES+1)) bits and SHALL saturate, never wrap.
REQ-015 A press event SHALL be a one-cycle pulse on the rising edge of the debounced level. Release SHALL generate no event.
REQ-016 The FSM states SHALL be STOP, RUN and CLEAR, with state encoded in registers.
REQ-017 STOP: en=0, clear=0. A run event SHALL go to RUN. A clear event SHALL go to CLEAR. If both events occur in the same cycle, clear SHALL take priority and the run event SHALL be discarded.
REQ-018 RUN: en=1, clear=0. A run event SHALL go to STOP. A clear event SHALL be ignored, and no queued clear SHALL remain afterwards.
REQ-019 CLEAR: en=0, clear=1 for exactly one cycle, then the FSM SHALL move unconditionally to STOP. Events arriving during CLEAR SHALL be ignored.
REQ-020 Each dir event SHALL toggle up_down, in any state.
REQ-021 Each mode event SHALL toggle mode, in any state.
REQ-022 All outputs SHALL be registered (Moore outputs) with no combinational path from any btn_* input.
REQ-023 Latency: an output change SHALL appear between DB_CYCLES+3 and DB_CYCLES+5 clk cycles after a clean raw edge.
REQ-024 A button held indefinitely SHALL produce exactly one event.
REQ-025 Glitches shorter than DB_CYCLES cycles SHALL produce no event.

Reset
REQ-026 While reset=1, the following SHALL hold asynchronously: state=STOP, en=0, clear=0, up_down=1, mode=0, all synchronizers and debounced levels=0, all debounce counters=0.
REQ-027 Reset asserted in any state, including mid-debounce or in CLEAR, SHALL abort the operation in progress.
REQ-028 After reset deasserts, a button already held high SHALL be treated as a fresh press and generate one event after DB_CYCLES stable cycles.

Verification (DB_CYCLES=4 for simulation)
REQ-029 Reset, then btn_run held 20 cycles -> en rises once, within 7-9 cycles of the edge. Release and press again -> en=0.
REQ-030 STOP, btn_clear pressed -> clear=1 for exactly 1 cycle with en=0. FSM returns to STOP and clear=0 thereafter.
REQ-031 RUN, btn_clear pressed -> clear stays 0 and en stays 1. After a run press returns the FSM to STOP, no delayed clear pulse occurs.
REQ-032 STOP, btn_run and btn_clear rising in the same cycle -> one clear pulse, en stays 0, final state STOP.
REQ-033 btn_dir bounces (1,0,1,0 with 2-cycle widths) and then holds 1 -> up_down goes from 1 to 0 exactly once. btn_mode pressed twice -> mode goes 0→1→0.
REQ-034 Reset asserted mid-RUN with up_down=0 and mode=1 -> same cycle: en=0, up_down=1, mode=0. No output activity until a new debounced press.
